ahb_verilog_arbiter: RTL and testbench
======================================

Name: ahb_verilog_arbiter

Overview:
- Round-robin AHB bus arbiter sharing one AHB slave fabric (address decoder plus slaves) between up to AHB_NUM_MASTERS masters.
- Drives HGRANT, HMASTER and HMASTLOCK to the master-side address/data mux.
- Holds ownership through locked sequences and through fixed-length bursts.
- Sits beside the address decoder in the bench fabric.

Parameters:
- AHB_NUM_MASTERS, 4, number of requesting masters (2..16).
- MASTER_ID_WIDTH, 2, width of HMASTER; must satisfy 2**MASTER_ID_WIDTH >= AHB_NUM_MASTERS.
- DEFAULT_MASTER, 0, master granted when nobody requests and after reset.

Ports:
- HCLK  input  1  bus clock; all state updates on its rising edge.
- HRESETn  input  1  reset, asynchronous assert, active-low.
- HBUSREQ  input  AHB_NUM_MASTERS  per-master bus request.
- HLOCK  input  AHB_NUM_MASTERS  per-master locked-access request.
- HTRANS  input  2  muxed transfer type of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HBURST  input  3  muxed burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- HREADY  input  1  bus ready; an arbitration point exists only when HREADY=1.
- HGRANT  output  AHB_NUM_MASTERS  one-hot grant.
- HMASTER  output  MASTER_ID_WIDTH  index of the master owning the address phase.
- HMASTLOCK  output  1  current address phase is part of a locked sequence.

Behaviour:
- Reset (async, HRESETn=0):
  - HGRANT = one-hot DEFAULT_MASTER.
  - HMASTER = DEFAULT_MASTER.
  - HMASTLOCK = 0.
  - FSM = ARB.
  - Beat counter = 0.
  - Round-robin pointer = DEFAULT_MASTER.
- Registers: all outputs are registered. HGRANT/HMASTER/HMASTLOCK change only on an HCLK edge where HREADY=1. When HREADY=0, every register holds.
- HMASTER handover: HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)] on each HREADY=1 edge. HMASTER therefore lags HGRANT by one arbitration point, which is the AHB address-phase handover.
- Winner selection (round-robin):
  - Search requesting masters starting at pointer+1, wrapping modulo AHB_NUM_MASTERS.
  - The pointer updates to the winner on every new grant.
  - If no HBUSREQ is set, grant DEFAULT_MASTER. The pointer does not move.
- FSM states:
  - ARB: a new grant is computed at each HREADY=1 edge.
    - Go to LOCKED if the winner's HLOCK=1.
    - Otherwise stay in ARB.
    - On HTRANS=NONSEQ with HBURST in {WRAP4..INCR16}, load the beat counter with the burst length minus 1 (3, 7 or 15) and go to BURST. The grant is held.
  - BURST: the grant is held.
    - The counter decrements on HREADY=1 with HTRANS=SEQ.
    - BUSY and IDLE do not decrement.
    - When the counter =1 and HREADY=1 with HTRANS=SEQ, re-arbitrate and go to ARB. The new owner takes the address phase right after the final beat.
    - Early termination: HTRANS=IDLE or NONSEQ while in BURST returns to ARB behaviour on that edge.
  - LOCKED: the grant is held while the owner's HLOCK=1.
    - When the owner's HLOCK=0 at an HREADY=1 edge, go to ARB, then perform one further held cycle so the locked transfer's final data phase completes.
    - HMASTLOCK clears one arbitration point after HLOCK drops.
- Undefined INCR bursts and SINGLE transfers are re-arbitrable at every arbitration point.
- Simultaneous lock and burst: LOCKED has priority. The burst counter still tracks, but the exit condition is the lock only.
- Grant to a non-requesting master: the grant is kept on the owner while it still requests; it is revoked only at an arbitration point.
- HGRANT is always exactly one-hot; no cycle with zero or multiple grants.
- Reset mid-burst or mid-lock: all state returns immediately to reset values. No burst completion is attempted.

Decomposition:
- Shared package ahb_arb_pkg:
  - HTRANS/HBURST encodings.
  - FSM state encoding (ARB, BURST, LOCKED).
  - Function returning burst beats per HBURST.
- Sub-module ahb_rr_pick: combinational rotate-priority picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner, index, any-request flag.
- FSM, beat counter and output registers live in the top module.

Test Plan:
- Reset: assert HRESETn=0 mid-run with HBUSREQ=4'b1111 -> immediately HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0. After release with no requests, HGRANT stays 4'b0001.
- Round-robin: HBUSREQ=4'b1111, SINGLE NONSEQ transfers, HREADY=1 -> HGRANT sequence 0010, 0100, 1000, 0001, 0010. HMASTER follows one cycle later: 1, 2, 3, 0.
- INCR4 hold: master 2 granted, issues NONSEQ+3×SEQ INCR4, all masters requesting, HREADY low for 2 cycles on beat 2 -> HGRANT stays 0100 for all 4 beats plus stalls. It moves to 1000 at the edge completing beat 4's address.
- Lock: master 1 with HLOCK=1 for 3 transfers while master 3 requests -> HGRANT=0010 and HMASTLOCK=1 throughout. Master 3 is granted only after HLOCK falls plus one held cycle.
- Early burst termination: master 0 starts INCR8, drives IDLE after beat 3 -> re-arbitration at that edge; master 1 is granted next.
- Stall: HREADY=0 for 5 cycles while HBUSREQ changes -> HGRANT, HMASTER and HMASTLOCK are unchanged for all 5 cycles.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the AHB arbiter: transfer/burst types, FSM states, burst length lookup.
// No logic state; constants and one pure function only.
// Imported by the arbiter top; the picker is encoding-agnostic.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic [1:0] ST_ARB    = 2'd0;
    localparam logic [1:0] ST_BURST  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Zero means the burst has no fixed length and stays re-arbitrable.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
            HBURST_SINGLE, HBURST_INCR:   burst_beats = 5'd0;
            default:                      burst_beats = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotate-priority picker: first requester after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is registered.
module ahb_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] win,
    output logic [W-1:0] win_idx,
    output logic         any_req
);

    int d;
    int best_d;

    // Distance from ptr+1 ranks each requester; smallest distance wins.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any_req = 1'b0;
        d       = 0;
        best_d  = 0;
        for (int k = 0; k < N; k++) begin
            d = k - int'(ptr) - 1;
            if (d < 0) d = d + N;
            if (req[k] && (!any_req || d < best_d)) begin
                any_req = 1'b1;
                best_d  = d;
                win     = '0;
                win[k]  = 1'b1;
                win_idx = W'(k);
            end
        end
    end

endmodule

// File: rtl/ahb_verilog_arbiter.sv
// Round-robin AHB arbiter with fixed-burst and locked-sequence hold.
// Latency: HGRANT registered one edge after request; HMASTER/HMASTLOCK one arbitration point later.
// Backpressure: HREADY=0 freezes every register; arbitration only happens on HREADY=1 edges.
module ahb_verilog_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int AHB_NUM_MASTERS = 4,
    parameter int MASTER_ID_WIDTH = 2,
    parameter int DEFAULT_MASTER  = 0
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [AHB_NUM_MASTERS-1:0] HBUSREQ,
    input  logic [AHB_NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]                 HTRANS,
    input  logic [2:0]                 HBURST,
    input  logic                       HREADY,
    output logic [AHB_NUM_MASTERS-1:0] HGRANT,
    output logic [MASTER_ID_WIDTH-1:0] HMASTER,
    output logic                       HMASTLOCK
);

    localparam logic [AHB_NUM_MASTERS-1:0] DEF_GRANT = AHB_NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MASTER_ID_WIDTH-1:0] DEF_IDX   = MASTER_ID_WIDTH'(DEFAULT_MASTER);

    logic [1:0]                 state, nxt_state;
    logic [3:0]                 beat_cnt, nxt_cnt;
    logic [MASTER_ID_WIDTH-1:0] ptr, nxt_ptr;
    logic [MASTER_ID_WIDTH-1:0] grant_idx, nxt_idx;
    logic [AHB_NUM_MASTERS-1:0] nxt_grant;
    logic                       lock_tail, nxt_tail;
    logic                       do_arb;

    logic [AHB_NUM_MASTERS-1:0] pick_win;
    logic [MASTER_ID_WIDTH-1:0] pick_idx;
    logic                       pick_any;

    ahb_rr_pick #(
        .N (AHB_NUM_MASTERS),
        .W (MASTER_ID_WIDTH)
    ) u_pick (
        .req     (HBUSREQ),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any_req (pick_any)
    );

    logic [3:0] burst_len;
    logic       burst_start;
    logic       owner_lock;
    logic       win_lock;

    assign burst_len   = 4'(burst_beats(HBURST) - 5'd1);
    assign burst_start = (HTRANS == HTRANS_NONSEQ) && (burst_beats(HBURST) != 5'd0);
    assign owner_lock  = |(HLOCK & HGRANT);
    assign win_lock    = pick_any && |(HLOCK & pick_win);

    always_comb begin
        nxt_grant = HGRANT;
        nxt_idx   = grant_idx;
        nxt_ptr   = ptr;
        nxt_state = state;
        nxt_cnt   = beat_cnt;
        nxt_tail  = lock_tail;
        do_arb    = 1'b0;
        case (state)
            ST_BURST: begin
                case (HTRANS)
                    HTRANS_IDLE, HTRANS_NONSEQ: do_arb = 1'b1;
                    HTRANS_SEQ: begin
                        if (beat_cnt == 4'd1) do_arb = 1'b1;
                        else                  nxt_cnt = beat_cnt - 4'd1;
                    end
                    HTRANS_BUSY: ;
                    default: ;
                endcase
            end
            ST_LOCKED: begin
                // Counter keeps tracking the burst, but only the lock releases the bus.
                if (burst_start)
                    nxt_cnt = burst_len;
                else if (HTRANS == HTRANS_SEQ && beat_cnt != 4'd0)
                    nxt_cnt = beat_cnt - 4'd1;
                if (!owner_lock) begin
                    nxt_state = ST_ARB;
                    nxt_tail  = 1'b1;
                end
            end
            default: begin
                if (lock_tail) nxt_tail = 1'b0;
                else           do_arb   = 1'b1;
            end
        endcase

        if (do_arb) begin
            if (burst_start) begin
                nxt_cnt   = burst_len;
                nxt_state = ST_BURST;
            end else begin
                nxt_cnt   = '0;
                nxt_grant = pick_any ? pick_win : DEF_GRANT;
                nxt_idx   = pick_any ? pick_idx : DEF_IDX;
                if (pick_any) nxt_ptr = pick_idx;
                nxt_state = win_lock ? ST_LOCKED : ST_ARB;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HGRANT    <= DEF_GRANT;
            grant_idx <= DEF_IDX;
            HMASTER   <= DEF_IDX;
            HMASTLOCK <= 1'b0;
            ptr       <= DEF_IDX;
            state     <= ST_ARB;
            beat_cnt  <= '0;
            lock_tail <= 1'b0;
        end else if (HREADY) begin
            HGRANT    <= nxt_grant;
            grant_idx <= nxt_idx;
            HMASTER   <= grant_idx;
            HMASTLOCK <= owner_lock;
            ptr       <= nxt_ptr;
            state     <= nxt_state;
            beat_cnt  <= nxt_cnt;
            lock_tail <= nxt_tail;
        end
    end

endmodule

// File: tb/tb_ahb_verilog_arbiter.sv
// Bench for ahb_verilog_arbiter: directed per-cycle vectors feed an expectation queue,
// and an independent monitor compares grant/master/lock after every clock or reset event.
module tb_ahb_verilog_arbiter;

    logic       HCLK;
    logic       HRESETn;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    ahb_verilog_arbiter #(
        .AHB_NUM_MASTERS (4),
        .MASTER_ID_WIDTH (2),
        .DEFAULT_MASTER  (0)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    localparam logic [1:0] IDL = 2'd0, BSY = 2'd1, NSQ = 2'd2, SEQ = 2'd3;
    localparam logic [2:0] SGL = 3'd0, IN4 = 3'd3, IN8 = 3'd5, I16 = 3'd7;

    typedef struct {
        logic [3:0] g;
        logic [1:0] m;
        logic       l;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   step_no = 0;

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic push_exp(input logic [3:0] eg, input logic [1:0] em, input logic el);
        exp_t e;
        step_no++;
        e.g  = eg;
        e.m  = em;
        e.l  = el;
        e.id = step_no;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; the expectation describes outputs after the coming rising edge.
    task automatic step(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rdy,
                        input logic [3:0] eg, input logic [1:0] em, input logic el);
        @(negedge HCLK);
        HRESETn = 1'b1;
        HBUSREQ = req;
        HLOCK   = lock;
        HTRANS  = tr;
        HBURST  = bu;
        HREADY  = rdy;
        push_exp(eg, em, el);
    endtask

    // Reset lands mid-cycle so only an asynchronous clear can satisfy the check.
    task automatic async_reset(input logic [3:0] req);
        @(negedge HCLK);
        HBUSREQ = req;
        push_exp(4'b0001, 2'd0, 1'b0);
        #2 HRESETn = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge HCLK or negedge HRESETn);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 3;
                if (HGRANT !== e.g) begin
                    errors++;
                    $display("FAIL step%0d grant: got %b expected %b", e.id, HGRANT, e.g);
                end
                if (HMASTER !== e.m) begin
                    errors++;
                    $display("FAIL step%0d master: got %0d expected %0d", e.id, HMASTER, e.m);
                end
                if (HMASTLOCK !== e.l) begin
                    errors++;
                    $display("FAIL step%0d mastlock: got %b expected %b", e.id, HMASTLOCK, e.l);
                end
            end
        end
    end

    initial begin
        HRESETn = 1'b0;
        HBUSREQ = 4'b0000;
        HLOCK   = 4'b0000;
        HTRANS  = IDL;
        HBURST  = SGL;
        HREADY  = 1'b1;
        #3 push_exp(4'b0001, 2'd0, 1'b0);

        // Idle after reset: default master keeps the grant.
        step(4'b0000, 4'b0000, IDL, SGL, 1'b1, 4'b0001, 2'd0, 1'b0);
        step(4'b0000, 4'b0000, IDL, SGL, 1'b1, 4'b0001, 2'd0, 1'b0);

        // Round-robin with everyone requesting single transfers.
        step(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 4'b0010, 2'd0, 1'b0);
        step(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 4'b0100, 2'd1, 1'b0);
        step(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 4'b1000, 2'd2, 1'b0);
        step(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 4'b0001, 2'd3, 1'b0);
        step(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 4'b0010, 2'd0, 1'b0);

        // Stall: requests and locks wiggle while HREADY is low.
        step(4'b0001, 4'b0001, NSQ, IN4, 1'b0, 4'b0010, 2'd0, 1'b0);
        step(4'b1000, 4'b1000, SEQ, IN8, 1'b0, 4'b0010, 2'd0, 1'b0);
        step(4'b0000, 4'b0010, IDL, SGL, 1'b0, 4'b0010, 2'd0, 1'b0);
        step(4'b0101, 4'b0100, NSQ, I16, 1'b0, 4'b0010, 2'd0, 1'b0);
        step(4'b1111, 4'b1111, NSQ, SGL, 1'b0, 4'b0010, 2'd0, 1'b0);
        step(4'b1111, 4'b0000, NSQ, SGL, 1'b1, 4'b0100, 2'd1, 1'b0);

        // INCR4 owned by master 2, two wait states on beat 2.
        step(4'b1111, 4'b0000, NSQ, IN4, 1'b1, 4'b0100, 2'd2, 1'b0);
        step(4'b1111, 4'b0000, SEQ, IN4, 1'b1, 4'b0100, 2'd2, 1'b0);
        step(4'b1111, 4'b0000, SEQ, IN4, 1'b0, 4'b0100, 2'd2, 1'b0);
        step(4'b1111, 4'b0000, SEQ, IN4, 1'b0, 4'b0100, 2'd2, 1'b0);
        step(4'b1111, 4'b0000, SEQ, IN4, 1'b1, 4'b0100, 2'd2, 1'b0);
        step(4'b1111, 4'b0000, SEQ, IN4, 1'b1, 4'b1000, 2'd2, 1'b0);

        // Locked sequence by master 1 while master 3 waits.
        step(4'b1010, 4'b0010, NSQ, SGL, 1'b1, 4'b0010, 2'd3, 1'b0);
        step(4'b1010, 4'b0010, NSQ, SGL, 1'b1, 4'b0010, 2'd1, 1'b1);
        step(4'b1010, 4'b0010, NSQ, SGL, 1'b1, 4'b0010, 2'd1, 1'b1);
        step(4'b1010, 4'b0010, NSQ, SGL, 1'b1, 4'b0010, 2'd1, 1'b1);
        step(4'b1010, 4'b0000, NSQ, SGL, 1'b1, 4'b0010, 2'd1, 1'b0);
        step(4'b1010, 4'b0000, NSQ, SGL, 1'b1, 4'b0010, 2'd1, 1'b0);
        step(4'b1010, 4'b0000, NSQ, SGL, 1'b1, 4'b1000, 2'd1, 1'b0);

        // INCR8 from master 0 cut short by IDLE after beat 3.
        step(4'b0011, 4'b0000, IDL, SGL, 1'b1, 4'b0001, 2'd3, 1'b0);
        step(4'b0011, 4'b0000, NSQ, IN8, 1'b1, 4'b0001, 2'd0, 1'b0);
        step(4'b0011, 4'b0000, SEQ, IN8, 1'b1, 4'b0001, 2'd0, 1'b0);
        step(4'b0011, 4'b0000, BSY, IN8, 1'b1, 4'b0001, 2'd0, 1'b0);
        step(4'b0011, 4'b0000, SEQ, IN8, 1'b1, 4'b0001, 2'd0, 1'b0);
        step(4'b0011, 4'b0000, IDL, IN8, 1'b1, 4'b0010, 2'd0, 1'b0);

        // Reset in the middle of an INCR16; no burst completion afterwards.
        step(4'b1111, 4'b0000, NSQ, I16, 1'b1, 4'b0010, 2'd1, 1'b0);
        step(4'b1111, 4'b0000, SEQ, I16, 1'b1, 4'b0010, 2'd1, 1'b0);
        async_reset(4'b1111);
        step(4'b0000, 4'b0000, IDL, SGL, 1'b1, 4'b0001, 2'd0, 1'b0);
        step(4'b0000, 4'b0000, IDL, SGL, 1'b1, 4'b0001, 2'd0, 1'b0);
        step(4'b1111, 4'b0000, SEQ, I16, 1'b1, 4'b0010, 2'd0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge HCLK);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
